// File: rtl/rotated_pixel_reader_pkg.sv
// Shared types and constants for the rotated frame-buffer read sequencer.
package rotated_pixel_reader_pkg;

    localparam int PIXEL_W = 24;

    typedef enum logic [1:0] {
        ROT_0   = 2'd0,
        ROT_90  = 2'd1,
        ROT_180 = 2'd2,
        ROT_270 = 2'd3
    } rot_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROW,
        ST_GAP,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/rotated_pixel_reader_if.sv
// Control, frame-buffer read port and pixel stream of the rotated reader.
// master = the reader, slave = frame buffer / downstream formatter side.
interface rotated_pixel_reader_if #(
    parameter int AW = 12
);
    import rotated_pixel_reader_pkg::*;

    logic                 frame_ready;
    logic [1:0]           rot_mode;
    logic                 rd_en;
    logic [AW-1:0]        rd_addr;
    logic [PIXEL_W-1:0]   rd_data;
    logic                 busy;
    logic                 frame_done;
    logic                 out_pixel_ready;
    logic                 out_pixel_valid;
    logic                 out_line_end;
    logic [PIXEL_W-1:0]   out_pixel_data;

    modport master (
        input  frame_ready, rot_mode, rd_data,
        output rd_en, rd_addr, busy, frame_done,
               out_pixel_ready, out_pixel_valid, out_line_end, out_pixel_data
    );

    modport slave (
        output frame_ready, rot_mode, rd_data,
        input  rd_en, rd_addr, busy, frame_done,
               out_pixel_ready, out_pixel_valid, out_line_end, out_pixel_data
    );

endinterface

// File: rtl/rotated_pixel_reader_rot_addr_gen.sv
// Output-raster counters and rotation mapping to a row-major source address.
// The counters always name the pixel whose address is currently on addr_o,
// so last_col_o/last_row_o describe the read being issued this cycle.
module rot_addr_gen
    import rotated_pixel_reader_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 48,
    parameter int AW    = 12
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [1:0]    mode_i,
    input  logic          step_i,
    output logic [AW-1:0] addr_o,
    output logic          last_col_o,
    output logic          last_row_o
);

    localparam int MAXD = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    localparam int CW   = $clog2(MAXD + 1);

    rot_mode_e       mode_q, mode_d;
    logic [CW-1:0]   r_q, r_d, c_q, c_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [CW-1:0]   w_m1, h_m1;
    logic [AW-1:0]   rr, cc, sr, sc;

    // Odd modes swap the output raster dimensions.
    assign w_m1       = mode_q[0] ? CW'(IMG_H - 1) : CW'(IMG_W - 1);
    assign h_m1       = mode_q[0] ? CW'(IMG_W - 1) : CW'(IMG_H - 1);
    assign last_col_o = (c_q == w_m1);
    assign last_row_o = (r_q == h_m1);
    assign addr_o     = addr_q;

    // Next counter position and its mapped source address.
    always_comb begin
        mode_d = start_i ? rot_mode_e'(mode_i) : mode_q;
        r_d    = r_q;
        c_d    = c_q;
        if (start_i) begin
            r_d = '0;
            c_d = '0;
        end else if (step_i) begin
            if (last_col_o) begin
                c_d = '0;
                r_d = last_row_o ? '0 : r_q + CW'(1);
            end else begin
                c_d = c_q + CW'(1);
            end
        end
        rr = AW'(r_d);
        cc = AW'(c_d);
        sr = rr;
        sc = cc;
        case (mode_d)
            ROT_0:   begin sr = rr;                    sc = cc;                    end
            ROT_90:  begin sr = AW'(IMG_H - 1) - cc;   sc = rr;                    end
            ROT_180: begin sr = AW'(IMG_H - 1) - rr;   sc = AW'(IMG_W - 1) - cc;   end
            ROT_270: begin sr = cc;                    sc = AW'(IMG_W - 1) - rr;   end
            default: begin sr = rr;                    sc = cc;                    end
        endcase
        addr_d = sr * AW'(IMG_W) + sc;
    end

    // Counter, mode and registered address state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q <= ROT_0;
            r_q    <= '0;
            c_q    <= '0;
            addr_q <= '0;
        end else begin
            mode_q <= mode_d;
            r_q    <= r_d;
            c_q    <= c_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/rotated_pixel_reader.sv
// Frame-buffer read sequencer: walks the rotated output raster, issues one
// read per cycle, and re-times the returned data into a pixel stream.
module rotated_pixel_reader
    import rotated_pixel_reader_pkg::*;
#(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 48,
    parameter int AW       = 12,
    parameter int LINE_GAP = 4
) (
    input  logic                   Clk_in,
    input  logic                   Rst_in,
    rotated_pixel_reader_if.master bus
);

    localparam int GW = $clog2(LINE_GAP + 2);

    state_e                state_q;
    logic                  rd_en_q, busy_q, done_q, first_q;
    logic [GW-1:0]         gap_q;
    logic                  start;
    logic [AW-1:0]         addr;
    logic                  last_col, last_row;

    // Read-side flags one cycle behind the issue, then the output stage.
    logic                  p1_vld_q, p1_le_q, p1_fs_q, p1_last_q;
    logic                  out_vld_q, out_le_q, out_fs_q, out_last_q;
    logic [PIXEL_W-1:0]    out_data_q;

    assign start = (state_q == ST_IDLE) && bus.frame_ready;

    rot_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .AW    (AW)
    ) u_addr (
        .clk_i      (Clk_in),
        .rst_i      (Rst_in),
        .start_i    (start),
        .mode_i     (bus.rot_mode),
        .step_i     (rd_en_q),
        .addr_o     (addr),
        .last_col_o (last_col),
        .last_row_o (last_row)
    );

    // Sequencer FSM with registered read strobe, busy and done.
    always_ff @(posedge Clk_in) begin
        if (Rst_in) begin
            state_q <= ST_IDLE;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            first_q <= 1'b0;
            gap_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.frame_ready) begin
                        state_q <= ST_ROW;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                        first_q <= 1'b1;
                    end
                end
                ST_ROW: begin
                    first_q <= 1'b0;
                    if (last_col) begin
                        if (last_row) begin
                            state_q <= ST_DRAIN;
                            rd_en_q <= 1'b0;
                        end else if (LINE_GAP > 0) begin
                            state_q <= ST_GAP;
                            rd_en_q <= 1'b0;
                            gap_q   <= '0;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_q == GW'(LINE_GAP - 1)) begin
                        state_q <= ST_ROW;
                        rd_en_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                ST_DRAIN: begin
                    // done follows the last output pixel; leave the cycle after
                    if (done_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (out_last_q) begin
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Two-stage read-to-output pipeline; data is zeroed on invalid cycles.
    always_ff @(posedge Clk_in) begin
        if (Rst_in) begin
            p1_vld_q   <= 1'b0;
            p1_le_q    <= 1'b0;
            p1_fs_q    <= 1'b0;
            p1_last_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            out_le_q   <= 1'b0;
            out_fs_q   <= 1'b0;
            out_last_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            p1_vld_q   <= rd_en_q;
            p1_le_q    <= rd_en_q & last_col;
            p1_fs_q    <= rd_en_q & first_q;
            p1_last_q  <= rd_en_q & last_col & last_row;
            out_vld_q  <= p1_vld_q;
            out_le_q   <= p1_le_q;
            out_fs_q   <= p1_fs_q;
            out_last_q <= p1_last_q;
            out_data_q <= p1_vld_q ? bus.rd_data : '0;
        end
    end

    assign bus.rd_en           = rd_en_q;
    assign bus.rd_addr         = addr;
    assign bus.busy            = busy_q;
    assign bus.frame_done      = done_q;
    assign bus.out_pixel_ready = out_fs_q;
    assign bus.out_pixel_valid = out_vld_q;
    assign bus.out_line_end    = out_le_q;
    assign bus.out_pixel_data  = out_data_q;

endmodule

// File: tb/tb_rotated_pixel_reader.sv
// Scoreboard bench: dut_a (LINE_GAP=2) and dut_b (LINE_GAP=0), 4x3 image,
// frame buffer returns data = address one cycle after rd_en.
module tb_rotated_pixel_reader;

    typedef struct packed {
        logic [23:0] data;
        logic        le;
        logic        fs;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   start_cyc[2];
    int   gap_cnt[2];
    bit   prev_le[2];
    bit   prev_last[2];
    bit   prev_done[2];

    // hand-computed output order per rotation mode for a 4x3 source
    int tab [4][12] = '{
        '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11},
        '{8, 4, 0, 9, 5, 1, 10, 6, 2, 11, 7, 3},
        '{11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0},
        '{3, 7, 11, 2, 6, 10, 1, 5, 9, 0, 4, 8}
    };

    rotated_pixel_reader_if #(.AW(4)) ifa ();
    rotated_pixel_reader_if #(.AW(4)) ifb ();

    rotated_pixel_reader #(.IMG_W(4), .IMG_H(3), .AW(4), .LINE_GAP(2)) dut_a (
        .Clk_in (clk), .Rst_in (rst_a), .bus (ifa.master)
    );
    rotated_pixel_reader #(.IMG_W(4), .IMG_H(3), .AW(4), .LINE_GAP(0)) dut_b (
        .Clk_in (clk), .Rst_in (rst_b), .bus (ifb.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // frame buffer models
    always @(posedge clk) ifa.rd_data <= ifa.rd_en ? 24'(ifa.rd_addr) : 24'hDEAD00;
    always @(posedge clk) ifb.rd_data <= ifb.rd_en ? 24'(ifb.rd_addr) : 24'hDEAD00;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic mon(input int d, input logic v, input logic le, input logic fs,
                       input logic dn, input logic bz, input logic [23:0] dat);
        exp_t  e;
        string p;
        bit    have;
        int    lg;
        p  = (d == 0) ? "a" : "b";
        lg = (d == 0) ? 2 : 0;
        chk({p, ".frame_done"}, int'(dn), int'(prev_last[d]));
        if (prev_done[d]) chk({p, ".busy_after_done"}, int'(bz), 0);
        if (dn) chk({p, ".busy_at_done"}, int'(bz), 1);
        if (v) begin
            have = (d == 0) ? (sb_a.size() != 0) : (sb_b.size() != 0);
            if (!have) begin
                checks++;
                failures++;
                $display("FAIL %s.unexpected_pixel actual=%0d required=none", p, dat);
                prev_last[d] = 1'b0;
            end else begin
                if (d == 0) e = sb_a.pop_front();
                else        e = sb_b.pop_front();
                chk({p, ".data"}, int'(dat), int'(e.data));
                chk({p, ".line_end"}, int'(le), int'(e.le));
                chk({p, ".pixel_ready"}, int'(fs), int'(e.fs));
                if (e.fs) chk({p, ".first_latency"}, cyc - start_cyc[d], 3);
                else      chk({p, ".row_gap"}, gap_cnt[d], prev_le[d] ? lg : 0);
                prev_le[d]   = e.le;
                prev_last[d] = e.last;
            end
            gap_cnt[d] = 0;
        end else begin
            chk({p, ".idle_data"}, int'(dat), 0);
            chk({p, ".idle_flags"}, int'({le, fs}), 0);
            gap_cnt[d]++;
            prev_last[d] = 1'b0;
        end
        prev_done[d] = dn;
    endtask

    always @(negedge clk) mon(0, ifa.out_pixel_valid, ifa.out_line_end, ifa.out_pixel_ready,
                              ifa.frame_done, ifa.busy, ifa.out_pixel_data);
    always @(negedge clk) mon(1, ifb.out_pixel_valid, ifb.out_line_end, ifb.out_pixel_ready,
                              ifb.frame_done, ifb.busy, ifb.out_pixel_data);

    task automatic chk_zero(input string p, input logic re, input logic bz, input logic dn,
                            input logic rdy, input logic v, input logic le,
                            input logic [3:0] ad, input logic [23:0] dat);
        chk({p, ".zero_ctl"}, int'({re, bz, dn}), 0);
        chk({p, ".zero_out"}, int'({rdy, v, le}), 0);
        chk({p, ".zero_addr"}, int'(ad), 0);
        chk({p, ".zero_data"}, int'(dat), 0);
    endtask

    // Called at a negedge: pulse frame_ready, queue the expected frame.
    task automatic start_frame(input int d, input int m);
        exp_t e;
        int   ow;
        ow = (m % 2 == 1) ? 3 : 4;
        for (int i = 0; i < 12; i++) begin
            e.data = 24'(tab[m][i]);
            e.le   = ((i % ow) == ow - 1);
            e.fs   = (i == 0);
            e.last = (i == 11);
            if (d == 0) sb_a.push_back(e);
            else        sb_b.push_back(e);
        end
        start_cyc[d] = cyc;
        if (d == 0) begin
            chk("a.busy_cycle0", int'(ifa.busy), 0);
            ifa.frame_ready = 1'b1;
            ifa.rot_mode    = 2'(m);
        end else begin
            chk("b.busy_cycle0", int'(ifb.busy), 0);
            ifb.frame_ready = 1'b1;
            ifb.rot_mode    = 2'(m);
        end
        @(negedge clk);
        if (d == 0) begin
            ifa.frame_ready = 1'b0;
            chk("a.busy_cycle1", int'(ifa.busy), 1);
            chk("a.rd_en_cycle1", int'(ifa.rd_en), 1);
            chk("a.first_addr", int'(ifa.rd_addr), tab[m][0]);
        end else begin
            ifb.frame_ready = 1'b0;
            chk("b.busy_cycle1", int'(ifb.busy), 1);
            chk("b.rd_en_cycle1", int'(ifb.rd_en), 1);
            chk("b.first_addr", int'(ifb.rd_addr), tab[m][0]);
        end
    endtask

    task automatic wait_idle(input int d);
        int  n;
        bit  idle;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            idle = (d == 0) ? (sb_a.size() == 0 && !ifa.busy) : (sb_b.size() == 0 && !ifb.busy);
        end while (!idle && n < 300);
        if (!idle) begin
            checks++;
            failures++;
            $display("FAIL timeout_frame_end actual=busy required=idle");
        end
    endtask

    initial begin
        int n;
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.frame_ready = 1'b0; ifa.rot_mode = 2'd0;
        ifb.frame_ready = 1'b0; ifb.rot_mode = 2'd0;
        repeat (3) @(negedge clk);
        chk_zero("a.reset", ifa.rd_en, ifa.busy, ifa.frame_done, ifa.out_pixel_ready,
                 ifa.out_pixel_valid, ifa.out_line_end, ifa.rd_addr, ifa.out_pixel_data);
        chk_zero("b.reset", ifb.rd_en, ifb.busy, ifb.frame_done, ifb.out_pixel_ready,
                 ifb.out_pixel_valid, ifb.out_line_end, ifb.rd_addr, ifb.out_pixel_data);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);

        // modes 0..2 back to back, each accepted the cycle after frame_done
        start_frame(0, 0); wait_idle(0);
        start_frame(0, 1); wait_idle(0);
        start_frame(0, 2); wait_idle(0);

        // mode 3 with a stray frame_ready and mode change during busy
        start_frame(0, 3);
        repeat (5) @(negedge clk);
        ifa.frame_ready = 1'b1;
        ifa.rot_mode    = 2'd2;
        @(negedge clk);
        ifa.frame_ready = 1'b0;
        wait_idle(0);
        repeat (20) @(negedge clk);

        // reset on the 5th pixel of a mode-0 frame
        start_frame(0, 0);
        n = 0;
        while (!(ifa.out_pixel_valid && ifa.out_pixel_data == 24'd4) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL timeout_fifth_pixel actual=none required=pixel4");
        end
        rst_a = 1'b1;
        @(negedge clk);
        chk_zero("a.midreset", ifa.rd_en, ifa.busy, ifa.frame_done, ifa.out_pixel_ready,
                 ifa.out_pixel_valid, ifa.out_line_end, ifa.rd_addr, ifa.out_pixel_data);
        sb_a.delete();
        rst_a = 1'b0;
        repeat (12) @(negedge clk);

        // frame_ready together with reset is dropped
        rst_a = 1'b1;
        ifa.frame_ready = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        ifa.frame_ready = 1'b0;
        chk("a.rst_vs_ready_busy", int'(ifa.busy), 0);
        chk("a.rst_vs_ready_rd_en", int'(ifa.rd_en), 0);
        @(negedge clk);
        chk("a.rst_vs_ready_busy2", int'(ifa.busy), 0);
        start_frame(0, 0); wait_idle(0);

        // zero line gap
        start_frame(1, 0); wait_idle(1);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rotated_pixel_reader.md
# rotated_pixel_reader

Frame-buffer read sequencer for the rotation datapath. Once a complete source frame is stored, it walks the output raster of the selected rotation (0°, 90° CW, 180°, 270° CW) and issues one read per cycle to the frame buffer. It emits pixels with frame-start, valid and line-end markers. It feeds the output-formatting stage directly: its `out_pixel_*` and `out_line_end` outputs drive that stage's inputs of the same names.

## Interface
- `IMG_W`, 64: source image width in pixels.
- `IMG_H`, 48: source image height in pixels.
- `AW`, 12: frame-buffer address width. Must satisfy 2^AW ≥ IMG_W*IMG_H.
- `LINE_GAP`, 4: idle cycles inserted between output rows. 0 is legal.
- `Clk_in`  in  1  sole clock. All logic is on the rising edge.
- `Rst_in`  in  1  reset, synchronous and active-high.
- `frame_ready`  in  1  pulse meaning the frame buffer holds a complete source frame.
- `rot_mode`  in  2  0=0°, 1=90° CW, 2=180°, 3=270° CW. Sampled only when `frame_ready` is accepted.
- `rd_en`  out  1  frame-buffer read strobe.
- `rd_addr`  out  AW  read address, row-major: src_row*IMG_W + src_col.
- `rd_data`  in  24  frame-buffer data. Valid exactly 1 cycle after `rd_en`.
- `busy`  out  1  frame output in progress.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame.
- `out_pixel_ready`  out  1  one-cycle frame-start pulse.
- `out_pixel_valid`  out  1  `out_pixel_data` carries a pixel.
- `out_line_end`  out  1  current pixel is the last pixel of its output row.
- `out_pixel_data`  out  24  RGB pixel.

## Operation
- **Output dimensions**
  - Modes 0 and 2: out_w=IMG_W, out_h=IMG_H.
  - Modes 1 and 3: out_w=IMG_H, out_h=IMG_W.
- **Output counters:** out_row r and out_col c.
  - c wraps at out_w-1 and then r increments.
  - The frame ends at (out_h-1, out_w-1).
- **Source mapping**
  - Mode 0: src = (r, c).
  - Mode 1: src = (IMG_H-1-c, r).
  - Mode 2: src = (IMG_H-1-r, IMG_W-1-c).
  - Mode 3: src = (c, IMG_W-1-r).
- **Address arithmetic**
  - Address computation is unsigned.
  - The product is truncated to AW bits; the AW constraint guarantees this is lossless.
  - Incremental stepping or a multiplier are both acceptable. Either way, `rd_addr` must be a registered output.
- **FSM states**
  - IDLE: on `frame_ready`, latch `rot_mode` and go to ROW.
  - ROW: `rd_en`=1 every cycle. When the last column is issued: if this is the last row, go to DRAIN; else if LINE_GAP>0, go to GAP; otherwise stay in ROW on the next row.
  - GAP: `rd_en`=0 for exactly LINE_GAP cycles, then go to ROW.
  - DRAIN: wait until the last pixel has been output, pulse `frame_done`, then go to IDLE.
- **Read-to-output pipeline**
  - The registered output stage captures `rd_data` plus the delayed valid, line-end and frame-start flags.
  - `out_pixel_data` is 0 whenever `out_pixel_valid`=0.
- `out_line_end` is asserted only together with `out_pixel_valid`, on column out_w-1.
- `out_pixel_ready` coincides with the first `out_pixel_valid` of the frame.
- `busy` is high from the first ROW cycle through the `frame_done` cycle inclusive.
- **Boundary conditions**
  - `frame_ready` while `busy` is ignored.
  - `rot_mode` changes mid-frame have no effect.
  - `Rst_in` mid-frame: on the next edge, FSM=IDLE, counters=0, and the pipeline is flushed. No further valid, line-end or `frame_done` appears from the aborted frame.
  - `frame_ready` in the same cycle as `Rst_in`: reset wins.

## Timing
- Reset values: all outputs are 0, including `rd_addr`, `busy` and the `out_*` outputs.
- `frame_ready` sampled high at cycle 0:
  - cycle 1: `rd_en`=1, first address.
  - cycle 2: `rd_data` valid.
  - cycle 3: `out_pixel_valid`=1 and `out_pixel_ready`=1.
- Latency from `rd_en` to `out_pixel_valid` is 2 cycles.
- Within a row, throughput is one pixel per cycle. Valid has no bubbles inside a row.
- Frame length in issue cycles: out_h*out_w + (out_h-1)*LINE_GAP.
- `frame_done` pulses 1 cycle after the last `out_pixel_valid`. A new `frame_ready` is accepted in the cycle after `frame_done`.

## Structure
- **Shared package:**
  - `ROT_0`, `ROT_90`, `ROT_180`, `ROT_270` encodings.
  - `PIXEL_W`=24.
  - The FSM state enum.
- **Sub-module `rot_addr_gen`:** row/column counters, out_w/out_h selection and source-address mapping. It exposes `addr`, `last_col` and `last_row`.
- **Top level:** FSM, gap counter and the 2-stage output pipeline.

## Test plan
Bench settings: IMG_W=4, IMG_H=3, LINE_GAP=2. The frame buffer model holds data = address and has 1-cycle read latency.
- **Mode 0** → data 0..11 in order.
  - `out_line_end` on pixels 3, 7 and 11.
  - Gaps of 2 invalid cycles between rows.
  - `out_pixel_ready` on the first pixel only.
  - `frame_done` 1 cycle after pixel 11.
- **Mode 1** → rows 8,4,0 | 9,5,1 | 10,6,2 | 11,7,3, with `out_line_end` on every 3rd pixel.
- **Mode 2** → data 11..0. **Mode 3** → rows 3,7,11 | 2,6,10 | 1,5,9 | 0,4,8.
- **Latency and flags** → with `frame_ready` at cycle 0:
  - first valid at cycle 3.
  - `busy` spans cycle 1 through `frame_done`.
  - a second `frame_ready` pulse during `busy` produces no extra frame.
- **Reset mid-frame** → assert `Rst_in` on the 5th pixel:
  - all outputs are 0 on the next cycle.
  - no `frame_done` appears.
  - a following `frame_ready` in mode 0 yields a clean 0..11 frame.
- **LINE_GAP=0, mode 0** → 12 consecutive valid cycles with `out_line_end` on 3, 7 and 11.
